// File: rtl/up_counter_ctrl_pkg.sv
// Shared state encodings for the up-counter controller.
package up_counter_ctrl_pkg;

  localparam logic [1:0] ENC_IDLE = 2'b00;
  localparam logic [1:0] ENC_RUN  = 2'b01;
  localparam logic [1:0] ENC_HOLD = 2'b10;
  localparam logic [1:0] ENC_DONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    HOLD = ENC_HOLD,
    DONE = ENC_DONE
  } ctrl_state_t;

endpackage

// File: rtl/up_counter_en.sv
// Enable/clear up-counter datapath; clear takes priority over enable.
module up_counter_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + ONE;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/up_counter_ctrl.sv
// Command sequencer around up_counter_en: one-shot / auto-reload runs with
// pause, abort, and registered busy / terminal-count / completion flags.
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_busy;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_q;
  logic             w_clr;
  logic             w_en;
  logic             w_load;
  logic             w_tc;
  logic             w_done;
  logic             w_at_limit;

  up_counter_en #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_en),
    .q   (w_q)
  );

  assign w_at_limit = (w_q == r_limit);

  // Priority within each state: stop, then start, then pause, then count.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    w_load = 1'b0;
    w_tc   = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
          w_load = 1'b1;
          w_clr  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (pause) begin
          w_next = HOLD;
        end else if (!w_at_limit) begin
          w_en = 1'b1;
        end else if (r_mode) begin
          w_clr = 1'b1;
          w_tc  = 1'b1;
        end else begin
          w_next = DONE;
          w_done = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (!pause) begin
          w_next = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (start) begin
          w_next = RUN;
          w_load = 1'b1;
          w_clr  = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        w_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_limit <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_limit <= limit;
        r_mode  <= auto_reload;
      end
      r_busy <= (w_next == RUN) || (w_next == HOLD);
      r_tc   <= w_tc;
      r_done <= w_done;
    end
  end

  assign q    = w_q;
  assign busy = r_busy;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed self-checking bench for up_counter_ctrl (WIDTH=4).
module tb_up_counter_ctrl;
  import up_counter_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] q;
  logic       busy;
  logic       tc;
  logic       done;

  int n_chk = 0;
  int n_fail = 0;

  up_counter_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .limit       (limit),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted start; returns just after edge E0.
  task automatic do_start(input logic [3:0] lim, input logic mode);
    limit = lim;
    auto_reload = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_chk++; if (q !== 4'd0) begin n_fail++; $display("FAIL rst_hold_q: got %0d want 0", q); end
    n_chk++; if ({busy, tc, done} !== 3'b000) begin n_fail++; $display("FAIL rst_hold_flags: got %b want 000", {busy, tc, done}); end
    rst = 1'b0;
    tick();
    do_start(4'd9, 1'b0);
    tick(); tick(); tick();
    n_chk++; if (q !== 4'd3) begin n_fail++; $display("FAIL rst_pre_q: got %0d want 3", q); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (q !== 4'd0) begin n_fail++; $display("FAIL rst_async_q: got %0d want 0", q); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    n_chk++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_async_state: got %0d want 0", dut.r_state); end
    #1 rst = 1'b0;
    tick();
    n_chk++; if (q !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after: got q=%0d busy=%b want q=0 busy=0", q, busy); end
  endtask

  task automatic test_oneshot();
    do_start(4'd5, 1'b0);
    n_chk++; if (q !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL os_e0: got q=%0d busy=%b want q=0 busy=1", q, busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++; if (q !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL os_count: got q=%0d busy=%b done=%b want q=%0d busy=1 done=0", q, busy, done, k); end
    end
    tick();
    n_chk++; if (done !== 1'b1 || q !== 4'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL os_done: got done=%b q=%0d busy=%b want done=1 q=5 busy=0", done, q, busy); end
    tick();
    n_chk++; if (done !== 1'b0 || q !== 4'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL os_after: got done=%b q=%0d busy=%b want done=0 q=5 busy=0", done, q, busy); end
    n_chk++; if (dut.r_state !== DONE) begin n_fail++; $display("FAIL os_state: got %0d want 3", dut.r_state); end
    do_stop();
    n_chk++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL os_stop: got q=%0d busy=%b done=%b want 0 0 0", q, busy, done); end
  endtask

  task automatic test_autoreload();
    int pulses;
    pulses = 0;
    do_start(4'd3, 1'b1);
    n_chk++; if (q !== 4'd0) begin n_fail++; $display("FAIL ar_e0: got %0d want 0", q); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (tc === 1'b1) pulses++;
      n_chk++; if (q !== 4'(k % 4) || tc !== ((k % 4) == 0) || done !== 1'b0) begin n_fail++; $display("FAIL ar_seq: cycle %0d got q=%0d tc=%b done=%b want q=%0d tc=%b done=0", k, q, tc, done, k % 4, (k % 4) == 0); end
    end
    n_chk++; if (pulses != 3) begin n_fail++; $display("FAIL ar_pulses: got %0d want 3", pulses); end
    do_stop();
  endtask

  task automatic test_pause();
    do_start(4'd7, 1'b0);
    tick(); tick();
    n_chk++; if (q !== 4'd2) begin n_fail++; $display("FAIL pz_pre: got %0d want 2", q); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (q !== 4'd2 || busy !== 1'b1 || dut.r_state !== HOLD) begin n_fail++; $display("FAIL pz_hold: got q=%0d busy=%b st=%0d want q=2 busy=1 st=2", q, busy, dut.r_state); end
    end
    pause = 1'b0;
    tick();
    n_chk++; if (q !== 4'd2 || dut.r_state !== RUN) begin n_fail++; $display("FAIL pz_resume: got q=%0d st=%0d want q=2 st=1", q, dut.r_state); end
    for (int k = 3; k <= 7; k++) begin
      tick();
      n_chk++; if (q !== 4'(k) || done !== 1'b0) begin n_fail++; $display("FAIL pz_count: got q=%0d done=%b want q=%0d done=0", q, done, k); end
    end
    tick();
    n_chk++; if (done !== 1'b1 || q !== 4'd7) begin n_fail++; $display("FAIL pz_done: got done=%b q=%0d want done=1 q=7", done, q); end
    do_stop();
  endtask

  task automatic test_stop();
    do_start(4'd9, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    n_chk++; if (q !== 4'd4) begin n_fail++; $display("FAIL st_pre: got %0d want 4", q); end
    do_stop();
    n_chk++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0 || dut.r_state !== IDLE) begin n_fail++; $display("FAIL st_run: got q=%0d busy=%b tc=%b done=%b st=%0d want 0 0 0 0 0", q, busy, tc, done, dut.r_state); end
    tick();
    n_chk++; if (q !== 4'd0 || done !== 1'b0) begin n_fail++; $display("FAIL st_run_after: got q=%0d done=%b want 0 0", q, done); end
    do_start(4'd1, 1'b0);
    tick(); tick();
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL st_d_done: got %b want 1", done); end
    tick();
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    n_chk++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0 || dut.r_state !== IDLE) begin n_fail++; $display("FAIL st_both: got q=%0d busy=%b tc=%b done=%b st=%0d want 0 0 0 0 0", q, busy, tc, done, dut.r_state); end
    tick();
    n_chk++; if (busy !== 1'b0 || dut.r_state !== IDLE) begin n_fail++; $display("FAIL st_both_after: got busy=%b st=%0d want 0 0", busy, dut.r_state); end
  endtask

  task automatic test_corners();
    do_start(4'd0, 1'b0);
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL c0os_e0: got busy=%b done=%b want 1 0", busy, done); end
    tick();
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || q !== 4'd0) begin n_fail++; $display("FAIL c0os_done: got done=%b busy=%b q=%0d want 1 0 0", done, busy, q); end
    do_stop();
    do_start(4'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (tc !== 1'b1 || q !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL c0ar_tc: got tc=%b q=%0d busy=%b want 1 0 1", tc, q, busy); end
    end
    do_stop();
    n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL c0ar_stop: got tc=%b want 0", tc); end
    do_start(4'd15, 1'b1);
    for (int k = 0; k < 15; k++) tick();
    n_chk++; if (q !== 4'd15 || tc !== 1'b0) begin n_fail++; $display("FAIL c15_top: got q=%0d tc=%b want 15 0", q, tc); end
    tick();
    n_chk++; if (q !== 4'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL c15_wrap: got q=%0d tc=%b want 0 1", q, tc); end
    tick();
    n_chk++; if (q !== 4'd1 || tc !== 1'b0) begin n_fail++; $display("FAIL c15_next: got q=%0d tc=%b want 1 0", q, tc); end
    do_stop();
    do_start(4'd5, 1'b0);
    limit = 4'd2;
    auto_reload = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (q !== 4'd2) begin n_fail++; $display("FAIL chg_ignstart: got %0d want 2", q); end
    for (int k = 3; k <= 5; k++) begin
      tick();
      n_chk++; if (q !== 4'(k) || tc !== 1'b0) begin n_fail++; $display("FAIL chg_count: got q=%0d tc=%b want q=%0d tc=0", q, tc, k); end
    end
    tick();
    n_chk++; if (done !== 1'b1 || q !== 4'd5) begin n_fail++; $display("FAIL chg_done: got done=%b q=%0d want 1 5", done, q); end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_stop();
    test_corners();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
